// File: rtl/led_sequencer.sv
// Purpose : front-panel LED sequencer; debounces btn_n on mS ticks and steps a 5-LED pattern on 100 ms ticks.
// Latency : press accepted 2 refclk + DEBOUNCE_MS mS ticks after the pin edge; all outputs registered, one edge after their cause.
// Flow    : no backpressure; flags are consumed on the cycle they arrive. Optional macro LEDSEQ_AUTO_ADVANCE_EN adds idle auto-advance.
module led_sequencer #(
    parameter int DEBOUNCE_MS = 20,
    parameter int STEP_TENTHS = 2,
    parameter int AUTO_TENTHS = 100
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       mS_Flag,
    input  logic       hundredmS_Flag,
    input  logic       btn_n,
    output logic       btn_press,
    output logic [1:0] mode,
    output logic [4:0] led
);

    typedef enum logic [1:0] {
        M_OFF    = 2'd0,
        M_BLINK  = 2'd1,
        M_CHASE  = 2'd2,
        M_BOUNCE = 2'd3
    } mode_t;

    localparam logic [7:0] DEB_LIM   = 8'(DEBOUNCE_MS);
    localparam logic [7:0] STEP_LAST = 8'(STEP_TENTHS - 1);
    localparam logic [7:0] AUTO_LIM  = 8'(AUTO_TENTHS);

    // Input synchronizer; resets to the released level (btn_n high).
    logic       sync_meta;
    logic       sync_lvl;
    logic       pressed_lvl;

    // Debouncer state.
    logic       db_pressed;
    logic       db_pressed_d;
    logic [7:0] deb_cnt;
    logic [7:0] deb_cnt_d;
    logic       accept;

    // Mode / pattern state.
    mode_t      mode_q;
    mode_t      mode_d;
    logic [4:0] led_q;
    logic [4:0] led_d;
    logic       dir_left_q;
    logic       dir_left_d;
    logic [7:0] step_cnt_q;
    logic [7:0] step_cnt_d;
    logic       step_evt;

    // Any mode advance: accepted press or (optionally) idle timeout.
    logic       auto_adv;
    logic       advance;
    logic       btn_press_q;

    // Pattern loaded whenever a mode is entered.
    function automatic logic [4:0] entry_pattern(input mode_t m);
        logic [4:0] p;
        p = 5'b00000;
        case (m)
            M_CHASE:  p = 5'b00001;
            M_BOUNCE: p = 5'b00001;
            default:  p = 5'b00000;
        endcase
        return p;
    endfunction

    // Two-flop synchronizer for the asynchronous button pin.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_meta <= 1'b1;
            sync_lvl  <= 1'b1;
        end else begin
            sync_meta <= btn_n;
            sync_lvl  <= sync_meta;
        end
    end

    assign pressed_lvl = ~sync_lvl;

    // Debounce: count mS ticks where the input disagrees with the accepted state.
    always_comb begin
        deb_cnt_d    = deb_cnt;
        db_pressed_d = db_pressed;
        accept       = 1'b0;
        if (mS_Flag) begin
            if (pressed_lvl != db_pressed) begin
                if (deb_cnt + 8'd1 == DEB_LIM) begin
                    db_pressed_d = ~db_pressed;
                    deb_cnt_d    = 8'd0;
                    // Only the released->pressed flip counts as a press.
                    accept       = ~db_pressed;
                end else begin
                    deb_cnt_d = deb_cnt + 8'd1;
                end
            end else begin
                deb_cnt_d = 8'd0;
            end
        end
    end

    // Debounce state register and registered press pulse.
    always_ff @(posedge refclk) begin
        if (rst) begin
            db_pressed  <= 1'b0;
            deb_cnt     <= 8'd0;
            btn_press_q <= 1'b0;
        end else begin
            db_pressed  <= db_pressed_d;
            deb_cnt     <= deb_cnt_d;
            btn_press_q <= accept;
        end
    end

`ifdef LEDSEQ_AUTO_ADVANCE_EN
    logic [7:0] idle_cnt;

    assign auto_adv = hundredmS_Flag && (idle_cnt + 8'd1 == AUTO_LIM);

    // Idle timer: counts 100 ms ticks since the last mode change.
    always_ff @(posedge refclk) begin
        if (rst) begin
            idle_cnt <= 8'd0;
        end else if (advance) begin
            idle_cnt <= 8'd0;
        end else if (hundredmS_Flag) begin
            idle_cnt <= idle_cnt + 8'd1;
        end
    end
`else
    logic unused_auto_lim;

    assign auto_adv        = 1'b0;
    assign unused_auto_lim = ^AUTO_LIM;
`endif

    // A press and an idle timeout in the same cycle still advance only once.
    assign advance  = accept | auto_adv;
    assign step_evt = hundredmS_Flag && (step_cnt_q == STEP_LAST);

    // Next mode, pattern, direction and step count; a mode change beats a step.
    always_comb begin
        mode_d     = mode_q;
        led_d      = led_q;
        dir_left_d = dir_left_q;
        step_cnt_d = step_cnt_q;
        if (advance) begin
            mode_d     = mode_t'(mode_q + 2'd1);
            led_d      = entry_pattern(mode_d);
            dir_left_d = 1'b1;
            step_cnt_d = 8'd0;
        end else if (hundredmS_Flag) begin
            if (step_evt) begin
                step_cnt_d = 8'd0;
                case (mode_q)
                    M_BLINK: begin
                        led_d = ~led_q;
                    end
                    M_CHASE: begin
                        led_d = {led_q[3:0], led_q[4]};
                    end
                    M_BOUNCE: begin
                        // Turn around at either end without repeating the end pattern.
                        if (dir_left_q) begin
                            if (led_q == 5'b10000) begin
                                led_d      = 5'b01000;
                                dir_left_d = 1'b0;
                            end else begin
                                led_d = {led_q[3:0], 1'b0};
                            end
                        end else begin
                            if (led_q == 5'b00001) begin
                                led_d      = 5'b00010;
                                dir_left_d = 1'b1;
                            end else begin
                                led_d = {1'b0, led_q[4:1]};
                            end
                        end
                    end
                    default: begin
                        led_d = led_q;
                    end
                endcase
            end else begin
                step_cnt_d = step_cnt_q + 8'd1;
            end
        end
    end

    // Mode FSM and pattern registers.
    always_ff @(posedge refclk) begin
        if (rst) begin
            mode_q     <= M_OFF;
            led_q      <= 5'b00000;
            dir_left_q <= 1'b1;
            step_cnt_q <= 8'd0;
        end else begin
            mode_q     <= mode_d;
            led_q      <= led_d;
            dir_left_q <= dir_left_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    assign btn_press = btn_press_q;
    assign mode      = mode_q;
    assign led       = led_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with DEBOUNCE_MS=3, STEP_TENTHS=2; flags driven directly.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// With LEDSEQ_AUTO_ADVANCE_EN the idle timeout is set longer than any idle run in the earlier steps.
module tb_led_sequencer;

`ifdef LEDSEQ_AUTO_ADVANCE_EN
    localparam int AUTO_T = 20;
`else
    localparam int AUTO_T = 100;
`endif

    logic       refclk = 1'b0;
    logic       rst;
    logic       mS_Flag;
    logic       hundredmS_Flag;
    logic       btn_n;
    logic       btn_press;
    logic [1:0] mode;
    logic [4:0] led;

    int   total = 0;
    int   bad = 0;
    int   press_cnt = 0;
    int   base;
    logic pulse_at;
    logic pulse_next;

    logic [4:0] chase_exp [10] = '{5'b00001, 5'b00010, 5'b00010, 5'b00100, 5'b00100,
                                   5'b01000, 5'b01000, 5'b10000, 5'b10000, 5'b00001};
    logic [4:0] bounce_exp [16] = '{5'b00001, 5'b00010, 5'b00010, 5'b00100,
                                    5'b00100, 5'b01000, 5'b01000, 5'b10000,
                                    5'b10000, 5'b01000, 5'b01000, 5'b00100,
                                    5'b00100, 5'b00010, 5'b00010, 5'b00001};
    logic [1:0] wrap_exp [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

    always #5 refclk = ~refclk;

    led_sequencer #(
        .DEBOUNCE_MS (3),
        .STEP_TENTHS (2),
        .AUTO_TENTHS (AUTO_T)
    ) dut (
        .refclk         (refclk),
        .rst            (rst),
        .mS_Flag        (mS_Flag),
        .hundredmS_Flag (hundredmS_Flag),
        .btn_n          (btn_n),
        .btn_press      (btn_press),
        .mode           (mode),
        .led            (led)
    );

    always @(posedge refclk) begin
        if (btn_press === 1'b1) press_cnt <= press_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic ms_tick();
        mS_Flag = 1'b1;
        cyc();
        pulse_at = btn_press;
        mS_Flag = 1'b0;
        cyc();
        pulse_next = btn_press;
    endtask

    task automatic tenth_tick();
        hundredmS_Flag = 1'b1;
        cyc();
        hundredmS_Flag = 1'b0;
        cyc();
    endtask

    task automatic both_tick();
        mS_Flag = 1'b1;
        hundredmS_Flag = 1'b1;
        cyc();
        pulse_at = btn_press;
        mS_Flag = 1'b0;
        hundredmS_Flag = 1'b0;
        cyc();
        pulse_next = btn_press;
    endtask

    task automatic release_btn();
        btn_n = 1'b1;
        cyc(3);
        repeat (3) ms_tick();
    endtask

    task automatic press_btn();
        btn_n = 1'b0;
        cyc(3);
        repeat (3) ms_tick();
        release_btn();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        mS_Flag = 1'b0;
        hundredmS_Flag = 1'b0;
        btn_n = 1'b0;
        pulse_at = 1'b0;
        pulse_next = 1'b0;

        // Reset with the button held down.
        cyc(4);
        rst = 1'b0;
        cyc();
        chk("rst_mode", 5'(mode), 5'd0);
        chk("rst_led", led, 5'b00000);
        chk("rst_press", 5'(btn_press), 5'd0);
        cyc(2);
        chk("rst_no_press", 5'(press_cnt), 5'd0);
        ms_tick();
        ms_tick();
        chk("held_2tick_mode", 5'(mode), 5'd0);
        chk("held_2tick_press", 5'(press_cnt), 5'd0);
        ms_tick();
        chk("held_pulse", 5'(pulse_at), 5'd1);
        chk("held_pulse_width", 5'(pulse_next), 5'd0);
        chk("held_mode", 5'(mode), 5'd1);
        chk("held_press_cnt", 5'(press_cnt), 5'd1);
        release_btn();
        chk("release_no_pulse", 5'(press_cnt), 5'd1);
        chk("release_mode", 5'(mode), 5'd1);

        // Bounce rejection.
        do_reset();
        chk("rst2_mode", 5'(mode), 5'd0);
        base = press_cnt;
        btn_n = 1'b0;
        cyc(3);
        ms_tick();
        ms_tick();
        btn_n = 1'b1;
        cyc(3);
        ms_tick();
        btn_n = 1'b0;
        cyc(3);
        ms_tick();
        ms_tick();
        chk("bounce_no_press", 5'(press_cnt - base), 5'd0);
        chk("bounce_mode", 5'(mode), 5'd0);
        btn_n = 1'b1;
        cyc(3);
        ms_tick();
        btn_n = 1'b0;
        cyc(3);
        ms_tick();
        ms_tick();
        ms_tick();
        chk("stable_pulse", 5'(pulse_at), 5'd1);
        chk("stable_pulse_width", 5'(pulse_next), 5'd0);
        chk("stable_press_cnt", 5'(press_cnt - base), 5'd1);
        chk("stable_mode", 5'(mode), 5'd1);
        chk("blink_entry", led, 5'b00000);
        release_btn();

        // BLINK toggles every second tick.
        tenth_tick();
        chk("blink_t1", led, 5'b00000);
        tenth_tick();
        chk("blink_t2", led, 5'b11111);
        tenth_tick();
        chk("blink_t3", led, 5'b11111);
        tenth_tick();
        chk("blink_t4", led, 5'b00000);

        // CHASE walk and wrap.
        press_btn();
        chk("chase_mode", 5'(mode), 5'd2);
        chk("chase_entry", led, 5'b00001);
        for (int i = 0; i < 10; i++) begin
            tenth_tick();
            chk($sformatf("chase_t%0d", i + 1), led, chase_exp[i]);
        end

        // BOUNCE turnaround.
        press_btn();
        chk("bounce_mode3", 5'(mode), 5'd3);
        chk("bounce_entry", led, 5'b00001);
        for (int i = 0; i < 16; i++) begin
            tenth_tick();
            chk($sformatf("bounce_t%0d", i + 1), led, bounce_exp[i]);
        end

        // Press and step event in the same cycle while in BOUNCE.
        tenth_tick();
        chk("coll_pre_led", led, 5'b00001);
        btn_n = 1'b0;
        cyc(3);
        ms_tick();
        ms_tick();
        both_tick();
        chk("coll_pulse", 5'(pulse_at), 5'd1);
        chk("coll_mode", 5'(mode), 5'd0);
        chk("coll_led", led, 5'b00000);
        release_btn();

        // Four presses from OFF wrap back to OFF.
        for (int i = 0; i < 4; i++) begin
            press_btn();
            chk($sformatf("wrap_p%0d", i + 1), 5'(mode), 5'(wrap_exp[i]));
        end

        // Collision entering CHASE: entry pattern kept, step counter restarted.
        press_btn();
        chk("coll2_pre_mode", 5'(mode), 5'd1);
        tenth_tick();
        btn_n = 1'b0;
        cyc(3);
        ms_tick();
        ms_tick();
        both_tick();
        chk("coll2_mode", 5'(mode), 5'd2);
        chk("coll2_led", led, 5'b00001);
        release_btn();
        tenth_tick();
        chk("coll2_t1", led, 5'b00001);
        tenth_tick();
        chk("coll2_t2", led, 5'b00010);

        // Idle behaviour.
        press_btn();
        chk("idle_start_mode", 5'(mode), 5'd3);
        base = press_cnt;
`ifdef LEDSEQ_AUTO_ADVANCE_EN
        repeat (AUTO_T - 1) tenth_tick();
        chk("auto_before", 5'(mode), 5'd3);
        tenth_tick();
        chk("auto_mode", 5'(mode), 5'd0);
        chk("auto_led", led, 5'b00000);
        chk("auto_no_press", 5'(press_cnt - base), 5'd0);
`else
        repeat (300) tenth_tick();
        chk("noauto_mode", 5'(mode), 5'd3);
        chk("noauto_no_press", 5'(press_cnt - base), 5'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
